// File: rtl/axis_pkg.sv
// Shared types and defaults for the AXI-Stream arbiter blocks.
// State encoding is fixed so status taps can decode it directly.
package axis_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT1 = 2'd1,
    ST_GRANT2 = 2'd2
  } state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register.
// Upstream may load whenever the slot is empty or draining this cycle.
module axis_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  input  logic              i_ready
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              w_load;

  assign o_ready = ~r_valid | i_ready;
  assign w_load  = i_valid & o_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (r_valid & i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/axis_rr_arb2.sv
// Packet-aware round-robin arbiter for two AXI-Stream slaves.
// Grant is held from first beat through s_last, then re-arbitrated.
module axis_rr_arb2
  import axis_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data_1,
  input  logic              s_valid_1,
  output logic              s_ready_1,
  input  logic              s_last_1,
  input  logic [DATA_W-1:0] s_data_2,
  input  logic              s_valid_2,
  output logic              s_ready_2,
  input  logic              s_last_2,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              sel,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt_1,
  output logic [CNT_W-1:0]  pkt_cnt_2
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sel;
  logic               w_sel_nxt;
  logic [CNT_W-1:0]   r_cnt_1;
  logic [CNT_W-1:0]   r_cnt_2;
  logic               w_out_rdy;
  logic               w_rdy_1;
  logic               w_rdy_2;
  logic               w_acc_1;
  logic               w_acc_2;
  logic               w_in_valid;
  logic [DATA_W-1:0]  w_in_data;
  logic               w_in_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // In IDLE a tie goes to the port that did not win last time.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rdy_1     = 1'b0;
    w_rdy_2     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_valid_1 && (!s_valid_2 || r_sel)) begin
          w_state_nxt = ST_GRANT1;
          w_sel_nxt   = 1'b0;
        end else if (s_valid_2) begin
          w_state_nxt = ST_GRANT2;
          w_sel_nxt   = 1'b1;
        end
      end
      ST_GRANT1: begin
        w_rdy_1 = w_out_rdy;
        if (s_valid_1 && w_out_rdy && s_last_1)
          w_state_nxt = ST_IDLE;
      end
      ST_GRANT2: begin
        w_rdy_2 = w_out_rdy;
        if (s_valid_2 && w_out_rdy && s_last_2)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_acc_1    = s_valid_1 & w_rdy_1;
  assign w_acc_2    = s_valid_2 & w_rdy_2;
  assign w_in_valid = w_acc_1 | w_acc_2;
  assign w_in_data  = w_acc_2 ? s_data_2 : s_data_1;
  assign w_in_last  = w_acc_2 ? s_last_2 : s_last_1;

  axis_out_reg #(
    .DATA_W (DATA_W)
  ) u_out (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_in_valid),
    .i_data  (w_in_data),
    .i_last  (w_in_last),
    .o_ready (w_out_rdy),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_last  (m_last),
    .i_ready (m_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_1 <= '0;
      r_cnt_2 <= '0;
    end else begin
      if (w_acc_1 && s_last_1)
        r_cnt_1 <= r_cnt_1 + CNT_W'(1);
      if (w_acc_2 && s_last_2)
        r_cnt_2 <= r_cnt_2 + CNT_W'(1);
    end
  end

  assign s_ready_1 = w_rdy_1;
  assign s_ready_2 = w_rdy_2;
  assign sel       = r_sel;
  assign busy      = (r_state != ST_IDLE);
  assign pkt_cnt_1 = r_cnt_1;
  assign pkt_cnt_2 = r_cnt_2;

endmodule

// File: doc/axis_rr_arb2.md
Name: axis_rr_arb2

Overview:
- Packet-aware, round-robin arbiter plus output register for two 8-bit AXI-Stream slave ports feeding one master port.
- Replaces the externally driven sel of the 2:1 stream mux: the grant is chosen internally, held for a whole packet (through s_last), then released.
- Sits in front of the downstream consumer and exports the current grant and per-port packet counts for status.

Parameters:
- DATA_W, 8, width of s_data_1, s_data_2 and m_data.
- CNT_W, 16, width of the per-port completed-packet counters; counters wrap at 2^CNT_W.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- s_data_1  in  DATA_W  slave 1 data
- s_valid_1  in  1  slave 1 valid
- s_ready_1  out  1  slave 1 ready
- s_last_1  in  1  slave 1 end-of-packet
- s_data_2  in  DATA_W  slave 2 data
- s_valid_2  in  1  slave 2 valid
- s_ready_2  out  1  slave 2 ready
- s_last_2  in  1  slave 2 end-of-packet
- m_data  out  DATA_W  master data (registered)
- m_valid  out  1  master valid (registered)
- m_ready  in  1  downstream ready
- m_last  out  1  master end-of-packet (registered)
- sel  out  1  current/last grant: 0 = slave 1, 1 = slave 2 (registered)
- busy  out  1  1 while in GRANT1 or GRANT2
- pkt_cnt_1  out  CNT_W  packets from slave 1 accepted (s_last_1 beats accepted)
- pkt_cnt_2  out  CNT_W  packets from slave 2 accepted

Behaviour:
- Clock is clk. Reset is synchronous and active-high on port reset.
- Reset values: m_valid=0, m_data=0, m_last=0, sel=1 (so slave 1 wins the first tie), busy=0, pkt_cnt_1/2=0, state=IDLE. The s_ready_x outputs are 0 during and after reset until a grant is made.
- States:
  - IDLE: both s_ready_x=0.
    - Only s_valid_1 -> GRANT1, sel<=0.
    - Only s_valid_2 -> GRANT2, sel<=1.
    - Both valid -> grant the port not equal to the current sel (round-robin).
    - Neither valid -> stay in IDLE.
    - The decision is registered, so there is one bubble cycle per packet.
  - GRANTx: s_ready_x = ~m_valid | m_ready (combinational), and the other port's s_ready=0.
    - Beat accepted when s_valid_x & s_ready_x: m_data<=s_data_x, m_last<=s_last_x, m_valid<=1.
    - If the accepted beat has s_last_x=1: pkt_cnt_x increments (wrapping), and state -> IDLE on the next cycle.
- Output register:
  - If m_valid & m_ready and no new beat is accepted: m_valid<=0.
  - m_data and m_last hold while m_valid & ~m_ready (AXI-Stream stability).
  - Latency from slave accept to m_valid is 1 cycle. Throughput is 1 beat/cycle while m_ready=1.
- The grant never changes mid-packet, regardless of the other port's valid or of toggling s_valid_x on the granted port.
- Single-beat packets (s_valid and s_last in the first beat) are legal: GRANT for 1 cycle, then IDLE.
- s_last on a non-granted port is ignored; only accepted beats count.
- Reset mid-packet: state, output register and grant are cleared immediately on the next edge. The partial packet is dropped, with no m_last.
- busy = (state != IDLE).

Decomposition:
- Shared package axis_pkg: state encoding constants ST_IDLE=2'd0, ST_GRANT1=2'd1, ST_GRANT2=2'd2, and the default DATA_W.
- One natural sub-module: axis_out_reg (single-entry output register with the ready = ~valid | m_ready rule), reusable by other stream blocks.
- The arbiter FSM and the counters stay in the top module.

Test Plan:
- Reset held 2 cycles, then released with no valids -> all outputs at their reset values, state IDLE, s_ready_1=s_ready_2=0.
- Only slave 1 sends a 3-beat packet 0xA1,0xA2,0xA3 (last on 0xA3), m_ready=1 -> sel=0, m_data sequence A1,A2,A3 each one cycle after accept, m_last with A3, pkt_cnt_1=1, back to IDLE.
- Both valid continuously with 2-beat packets -> grants alternate 1,2,1,2 starting with slave 1. After 4 packets pkt_cnt_1=2, pkt_cnt_2=2, with no interleaving of beats within a packet.
- Slave 2 granted, m_ready low for 3 cycles mid-packet -> m_data/m_last stable and s_ready_2=0 while m_valid=1. Transfer resumes with no lost or duplicated beat.
- Reset asserted after the 2nd beat of a 4-beat slave 1 packet -> next cycle m_valid=0, busy=0, sel=1. After release a fresh slave 2 packet is granted normally.
- Counter wrap with CNT_W=2 -> after 4 single-beat packets on slave 1, pkt_cnt_1 reads 0.
